// File: rtl/branch_predict_unit.sv
// Branch condition evaluator with a direct-mapped table of 2-bit saturating predictors.
// Define BRANCH_STATS_EN to add saturating branch/mispredict event counters.
module branch_predict_unit #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk_pi,
  input  logic              reset_pi,
  input  logic [PC_W-1:0]   fetch_pc_pi,
  output logic              predict_taken_po,
  input  logic              resolve_valid_pi,
  input  logic [PC_W-1:0]   resolve_pc_pi,
  input  logic              predicted_taken_pi,
  input  logic [2:0]        cond_sel_pi,
  input  logic              signed_cmp_pi,
  input  logic [DATA_W-1:0] reg1_data_pi,
  input  logic [DATA_W-1:0] reg2_data_pi,
  input  logic              alu_carry_bit_pi,
  input  logic              flush_pi,
  output logic              resolve_valid_po,
  output logic              is_branch_taken_po,
  output logic              mispredict_po,
  output logic              ready_po
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       branch_count_po,
  output logic [31:0]       mispredict_count_po
`endif
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0]       table_q [ENTRIES];
  logic [IDX_W-1:0] init_idx;
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] res_idx;
  logic             cond_taken;
  logic             cond_trains;
  logic             accepted;
  logic             train;
  logic             ge_res;
  logic             le_res;
  logic [1:0]       cur_ctr;
  logic [1:0]       next_ctr;
  logic             unused_pc_bits;

  assign fetch_idx      = fetch_pc_pi[IDX_W-1:0];
  assign res_idx        = resolve_pc_pi[IDX_W-1:0];
  // Aliasing above the index bits is intentional; the upper PC bits are dropped.
  assign unused_pc_bits = ^{fetch_pc_pi, resolve_pc_pi};

  assign ge_res = signed_cmp_pi ? ($signed(reg1_data_pi) >= $signed(reg2_data_pi))
                                : (reg1_data_pi >= reg2_data_pi);
  assign le_res = signed_cmp_pi ? ($signed(reg1_data_pi) <= $signed(reg2_data_pi))
                                : (reg1_data_pi <= reg2_data_pi);

  always_comb begin
    cond_taken  = 1'b0;
    cond_trains = 1'b1;
    case (cond_sel_pi)
      3'd1:    cond_taken = (reg1_data_pi == reg2_data_pi);
      3'd2:    cond_taken = ge_res;
      3'd3:    cond_taken = le_res;
      3'd4:    cond_taken = alu_carry_bit_pi;
      3'd5:    cond_taken = (reg1_data_pi != reg2_data_pi);
      3'd6:    cond_taken = 1'b1;
      default: cond_trains = 1'b0;
    endcase
  end

  assign accepted = resolve_valid_pi & ~flush_pi & ready_po;
  assign train    = accepted & cond_trains;
  assign cur_ctr  = table_q[res_idx];

  always_comb begin
    next_ctr = cur_ctr;
    if (cond_taken) begin
      if (cur_ctr != 2'b11) next_ctr = cur_ctr + 2'b01;
    end else begin
      if (cur_ctr != 2'b00) next_ctr = cur_ctr - 2'b01;
    end
  end

  // Read-before-write: the lookup sees the table contents from before this edge.
  assign predict_taken_po = ready_po & table_q[fetch_idx][1];

  always_ff @(posedge clk_pi) begin
    if (!ready_po) begin
      table_q[init_idx] <= 2'b01;
    end else if (train) begin
      table_q[res_idx] <= next_ctr;
    end
  end

  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) begin
      ready_po           <= 1'b0;
      init_idx           <= '0;
      resolve_valid_po   <= 1'b0;
      is_branch_taken_po <= 1'b0;
      mispredict_po      <= 1'b0;
    end else begin
      if (!ready_po) begin
        init_idx <= init_idx + 1'b1;
        if (init_idx == '1) ready_po <= 1'b1;
      end
      resolve_valid_po <= accepted;
      mispredict_po    <= accepted & (cond_taken != predicted_taken_pi);
      if (accepted) is_branch_taken_po <= cond_taken;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) begin
      branch_count_po     <= '0;
      mispredict_count_po <= '0;
    end else begin
      if (train && (branch_count_po != '1)) branch_count_po <= branch_count_po + 32'd1;
      if (resolve_valid_po && mispredict_po && (mispredict_count_po != '1))
        mispredict_count_po <= mispredict_count_po + 32'd1;
    end
  end
`endif

endmodule
